// File: rtl/logic_unit_sched_if.sv
// Request/response bundle between the requesters/consumer and the shared logic-unit scheduler.
interface logic_unit_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_opA;
    logic [NUM_REQ*WIDTH-1:0] req_opB;
    logic [NUM_REQ*2-1:0]     req_op;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WIDTH-1:0]         resp_result;
    logic [ID_W-1:0]          resp_id;

    modport master (
        output req_valid, req_opA, req_opB, req_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_id
    );

    modport slave (
        input  req_valid, req_opA, req_opB, req_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_id
    );
endinterface

// File: rtl/logic_unit_sched.sv
// Shares one AND/OR/XOR/NOR unit among NUM_REQ requesters; round-robin grant by default,
// fixed priority (lowest index wins) when LOGIC_SCHED_FIXED_PRI_EN is defined.
module logic_unit_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    logic_unit_sched_if.slave    bus,
    output logic [15:0]          served_count_o
);

    logic [NUM_REQ-1:0][WIDTH-1:0] op_a, op_b;
    logic [NUM_REQ-1:0][1:0]       op_sel;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_a[i]   = bus.req_opA[i*WIDTH +: WIDTH];
        assign op_b[i]   = bus.req_opB[i*WIDTH +: WIDTH];
        assign op_sel[i] = bus.req_op[i*2 +: 2];
    end

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    logic_op = a & b;
            2'd1:    logic_op = a | b;
            2'd2:    logic_op = a ^ b;
            default: logic_op = ~(a | b);
        endcase
    endfunction

    logic                 resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]     resp_result_q, resp_result_d;
    logic [ID_W-1:0]      resp_id_q, resp_id_d;
    logic [15:0]          served_q, served_d;
    logic [ID_W-1:0]      rr_ptr;
    logic                 gnt_vld;
    logic [ID_W-1:0]      gnt_idx;
    logic [ID_W-1:0]      scan_idx;
    logic                 can_accept;
    logic                 accept;
    logic [NUM_REQ-1:0]   req_ready;

`ifdef LOGIC_SCHED_FIXED_PRI_EN
    assign rr_ptr = '0;
`else
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    assign rr_ptr_d = accept ? gnt_idx + ID_W'(1) : rr_ptr_q;
    assign rr_ptr   = rr_ptr_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) rr_ptr_q <= '0;
        else           rr_ptr_q <= rr_ptr_d;
    end
`endif

    // NUM_REQ is a power of two, so the ID_W-bit add wraps the scan naturally.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = rr_ptr + ID_W'(k);
            if (!gnt_vld && bus.req_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    assign can_accept = ~resp_valid_q | bus.resp_ready;
    assign accept     = gnt_vld & can_accept;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

    assign bus.req_ready = req_ready;

    always_comb begin
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_id_d     = resp_id_q;
        served_d      = served_q;
        if (accept) begin
            resp_valid_d  = 1'b1;
            resp_result_d = logic_op(op_sel[gnt_idx], op_a[gnt_idx], op_b[gnt_idx]);
            resp_id_d     = gnt_idx;
            served_d      = served_q + 16'd1;
        end else if (bus.resp_ready) begin
            resp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_id_q     <= '0;
            served_q      <= '0;
        end else begin
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_id_q     <= resp_id_d;
            served_q      <= served_d;
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_id     = resp_id_q;
    assign served_count_o  = served_q;

endmodule

// File: tb/tb_logic_unit_sched.sv
// Directed + random bench for logic_unit_sched with a reference grant model and result scoreboard.
module tb_logic_unit_sched;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int WIDTH   = 32;
`ifdef LOGIC_SCHED_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] served_count;

    logic_unit_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH)) bus ();

    logic_unit_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH)) dut (
        .clk_i          (clk),
        .resetn_i       (resetn),
        .bus            (bus),
        .served_count_o (served_count)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    int   m_rr    = 0;
    bit   m_valid = 1'b0;
    logic [15:0] m_count = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        bus.req_opA[i*WIDTH +: WIDTH] = a;
        bus.req_opB[i*WIDTH +: WIDTH] = b;
        bus.req_op[i*2 +: 2]          = op;
    endtask

    task automatic model_reset();
        m_rr    = 0;
        m_valid = 1'b0;
        m_count = '0;
        sb.delete();
    endtask

    // One clock: check outputs at the falling edge against the model, then advance the model.
    task automatic cycle();
        bit   can, found;
        int   g;
        logic [NUM_REQ-1:0] exp_rdy;
        exp_t e;
        @(negedge clk);
        can   = !m_valid || bus.resp_ready;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_rr + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        exp_rdy = (found && can) ? NUM_REQ'(1) << g : '0;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
        chk("served_count", 32'(served_count), 32'(m_count));
        if (m_valid && sb.size() != 0) begin
            e = sb[0];
            chk("resp_result", bus.resp_result, e.res);
            chk("resp_id", 32'(bus.resp_id), 32'(e.id));
        end
        if (m_valid && bus.resp_ready && sb.size() != 0) void'(sb.pop_front());
        if (found && can) begin
            e.id  = ID_W'(g);
            e.res = ref_op(bus.req_op[g*2 +: 2], bus.req_opA[g*WIDTH +: WIDTH], bus.req_opB[g*WIDTH +: WIDTH]);
            sb.push_back(e);
            m_count = m_count + 16'd1;
            m_rr    = FIXED ? 0 : (g + 1) % NUM_REQ;
            m_valid = 1'b1;
        end else if (bus.resp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn         = 1'b0;
        bus.req_valid  = '0;
        bus.req_opA    = '0;
        bus.req_opB    = '0;
        bus.req_op     = '0;
        bus.resp_ready = 1'b0;
        #3;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_result", bus.resp_result, 32'h0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'h0);
        chk("rst_served", 32'(served_count), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Single XOR request from requester 2
        bus.resp_ready = 1'b1;
        set_req(2, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd2);
        bus.req_valid = 4'b0100;
        cycle();
        bus.req_valid = 4'b0000;
        chk("single_result", bus.resp_result, 32'h0FF0_0FF0);
        chk("single_id", 32'(bus.resp_id), 32'h2);
        chk("single_count", 32'(served_count), 32'h1);
        cycle();
        cycle();

        // All requesters NOR with zero operands
        resetn = 1'b0; model_reset(); #1; resetn = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h0, 32'h0, 2'd3);
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("nor_result", bus.resp_result, 32'hFFFF_FFFF);
            if (!FIXED) chk("rr_order", 32'(bus.resp_id), 32'(i % NUM_REQ));
        end

        // Random operands, valids and consumer backpressure
        for (int i = 0; i < 60; i++) begin
            for (int r = 0; r < NUM_REQ; r++)
                set_req(r, $urandom, $urandom, 2'($urandom_range(0, 3)));
            bus.req_valid  = 4'($urandom);
            bus.resp_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        bus.resp_ready = 1'b1;
        bus.req_valid  = '0;
        cycle(); cycle();

        // Backpressure: accept req 1, stall 3 cycles, then drain-and-reload at one edge
        set_req(1, 32'h1234_5678, 32'h0F0F_0F0F, 2'd0);
        bus.req_valid = 4'b0010;
        cycle();
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_result", bus.resp_result, 32'h0204_0608);
            chk("bp_id", 32'(bus.resp_id), 32'h1);
        end
        bus.resp_ready = 1'b1;
        cycle();
        chk("bp_reload_valid", 32'(bus.resp_valid), 32'h1);
        cycle(); cycle();

`ifdef LOGIC_SCHED_FIXED_PRI_EN
        bus.req_valid = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            chk("fixed_no_req3", 32'(bus.req_ready[3]), 32'h0);
            cycle();
            chk("fixed_id0", 32'(bus.resp_id), 32'h0);
        end
`endif

        // Counter wrap after 65536 back-to-back accepts
        resetn = 1'b0; model_reset(); #1; resetn = 1'b1;
        bus.req_valid  = 4'b1111;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 65536; i++) cycle();
        chk("wrap_count", 32'(served_count), 32'h0);
        chk("wrap_pending", 32'(bus.resp_valid), 32'h1);

        // Reset while a response is pending
        bus.resp_ready = 1'b0;
        cycle();
        resetn = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_mid_count", 32'(served_count), 32'h0);
        model_reset();
        bus.req_valid = 4'b1010;
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.resp_ready = 1'b1;
        #1;
        chk("rr_after_reset", 32'(bus.req_ready), 32'h2);
        cycle();
        cycle();
        bus.req_valid = '0;
        cycle(); cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/logic_unit_sched.md
# logic_unit_sched

Scheduler that shares one 32-bit scalar logic unit (AND/OR/XOR/NOR) among NUM_REQ requesters in the scalar/vector datapath. Each cycle it picks one valid requester, computes its operation, and holds the result in a one-entry output register with the requester ID until the consumer accepts it. Arbitration is round-robin by default. A fixed-priority mode can be compiled in instead.

## Interface
- NUM_REQ, 4, number of requesters; power of two, 2..8
- ID_W, 2, log2(NUM_REQ)
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_opA  in  NUM_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
- req_opB  in  NUM_REQ*WIDTH  operand B, same packing
- req_op  in  NUM_REQ*2  op per requester at [i*2 +: 2]: 0 AND, 1 OR, 2 XOR, 3 NOR(~(A|B))
- req_ready  out  NUM_REQ  one-hot or zero; the request is accepted when req_valid[i]&req_ready[i] at a clock edge
- resp_valid  out  1  result register holds a valid result
- resp_ready  in  1  consumer accepts the result when resp_valid&resp_ready
- resp_result  out  WIDTH  registered logic result
- resp_id  out  ID_W  index of the requester that produced resp_result
- served_count  out  16  count of accepted requests; wraps

## Operation
- Reset (resetn=0, asynchronous): resp_valid=0, resp_result=0, resp_id=0, served_count=0, rr_ptr=0. req_ready is combinational and is therefore 0 whenever req_valid=0.
- can_accept = ~resp_valid | resp_ready.
- Grant (combinational): scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ. The first index with req_valid set is granted.
- req_ready[g] = can_accept for the granted index g. All other req_ready bits are 0. If no request is valid, all bits are 0.
- On accept (valid&ready for g):
  - resp_result ← op(opA[g], opB[g]), resp_id ← g, resp_valid ← 1.
  - served_count ← served_count+1 mod 2^16.
  - rr_ptr ← (g+1) mod NUM_REQ.
- On resp_valid&resp_ready with no new accept: resp_valid ← 0. resp_result and resp_id hold their last values.
- No accept: rr_ptr and served_count are unchanged.
- A requester may drop req_valid before it is accepted. Grant is recomputed every cycle, and there is no lock.
- While resp_valid=1 and resp_ready=0, resp_result and resp_id stay stable and all req_ready bits are 0.

## Timing
- Latency: accepted at edge N → resp_valid=1 with the result during cycle N+1.
- Throughput: one accept per cycle while resp_ready stays high. The register is drained and reloaded at the same edge.
- req_ready depends combinationally on req_valid, rr_ptr, resp_valid and resp_ready. There is no path from operands to req_ready.
- resp_* are driven only from registers. There is no combinational path from req_* to resp_*.
- served_count wraps from 0xFFFF to 0x0000 on the next accept.
- If resetn is asserted while a response is pending, the response is dropped: resp_valid falls immediately and no handshake completes.

## Configuration
- LOGIC_SCHED_FIXED_PRI_EN defined: fixed priority.
  - The scan always starts at index 0, so the lowest index wins.
  - rr_ptr is not implemented and is treated as constant 0.
  - All other behaviour is identical.
- Undefined (default): round-robin as described above.

## Test plan
- Reset, then hold req_valid=0 → resp_valid=0, req_ready=0, served_count=0, resp_result=0.
- Single request: req 2, opA=0xF0F0_F0F0, opB=0xFF00_FF00, op=2, resp_ready=1 → the cycle after accept: resp_valid=1, resp_result=0x0FF0_0FF0, resp_id=2, served_count=1.
- All four requesters valid continuously, resp_ready=1, default build:
  - Grant order is 0,1,2,3,0,…, one accept per cycle.
  - With op=3 and A=B=0 everywhere, every resp_result=0xFFFF_FFFF.
- Backpressure:
  - Accept req 1, then hold resp_ready=0 for 3 cycles → req_ready=0 throughout and resp_* stable.
  - Raise resp_ready → the next request is accepted at that same edge, and its result follows one cycle later.
- Wrap: run 65536 accepts → served_count returns to 0. Assert resetn=0 mid-pending → resp_valid=0 immediately and rr_ptr=0 after release.
- With LOGIC_SCHED_FIXED_PRI_EN: reqs 0 and 3 both held valid → requester 0 is granted every cycle and requester 3 never receives req_ready.
